// File: rtl/slac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : slac_pkg                                                   |
// | Shared types and arithmetic helpers for the psum accumulation path.  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package slac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2,
        DRAIN = 2'd3
    } psum_state_e;

    // Signed add of two sign-extended words, clamped to the range of a
    // 'width'-bit signed word (width <= 31). Caller truncates the result.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int width);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = 33'(a) + 33'(b);
        hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (width - 1));
        if (sum > hi) begin
            sum = hi;
        end else if (sum < lo) begin
            sum = lo;
        end
        return 32'(sum);
    endfunction

    // Clamp negative values to zero.
    function automatic logic signed [31:0] relu(input logic signed [31:0] x);
        return (x < 0) ? 32'sd0 : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_accum_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : psum_accum_buffer_if                                     |
// | Job config, psum input pulse and ofmap valid/ready output bundle.    |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
interface psum_accum_buffer_if #(
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_OFMAP_WIDTH = 64,
    parameter int MAX_PASSES      = 256
);
    logic                                i_start;
    logic [$clog2(MAX_OFMAP_WIDTH):0]    i_ofmap_width;
    logic [$clog2(MAX_PASSES):0]         i_num_pass;
    logic                                i_relu_en;
    logic signed [DATA_WIDTH-1:0]        i_psum_data;
    logic                                i_psum_valid;
    logic signed [DATA_WIDTH-1:0]        o_ofmap_data;
    logic                                o_ofmap_valid;
    logic                                i_ofmap_ready;
    logic                                o_busy;
    logic                                o_done;
    logic                                o_drop_err;

    modport slave (
        input  i_start, i_ofmap_width, i_num_pass, i_relu_en,
        input  i_psum_data, i_psum_valid, i_ofmap_ready,
        output o_ofmap_data, o_ofmap_valid, o_busy, o_done, o_drop_err
    );

    modport master (
        output i_start, i_ofmap_width, i_num_pass, i_relu_en,
        output i_psum_data, i_psum_valid, i_ofmap_ready,
        input  o_ofmap_data, o_ofmap_valid, o_busy, o_done, o_drop_err
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sync_fifo                                                   |
// | Show-ahead synchronous FIFO; a push is accepted when full if a pop   |
// | happens in the same cycle. Output reads 0 while empty.               |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (c_PTR_W + 1)'(FIFO_DEPTH));
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset because reads are gated by empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end
endmodule
`default_nettype wire

// File: rtl/psum_accum_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : psum_accum_buffer                                           |
// | Accumulates per-column psums over several passes, then pushes the    |
// | (optionally ReLU'd) final sums into an output FIFO.                  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module psum_accum_buffer
    import slac_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_OFMAP_WIDTH = 64,
    parameter int MAX_PASSES      = 256,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                clk,
    input  logic                reset,
    psum_accum_buffer_if.slave  bus
);
    localparam int c_COL_W  = $clog2(MAX_OFMAP_WIDTH);
    localparam int c_PASS_W = $clog2(MAX_PASSES);
    localparam int c_WID_W  = c_COL_W + 1;
    localparam int c_NP_W   = c_PASS_W + 1;

    psum_state_e                  r_state;
    psum_state_e                  w_next_state;
    logic [c_COL_W-1:0]           r_col_ptr;
    logic [c_PASS_W-1:0]          r_pass_ptr;
    logic [c_WID_W-1:0]           r_width;
    logic [c_NP_W-1:0]            r_num_pass;
    logic                         r_relu_en;
    logic                         r_drop_err;
    logic signed [DATA_WIDTH-1:0] r_buf [MAX_OFMAP_WIDTH];

    logic                         w_accept;
    logic                         w_last_col;
    logic [c_NP_W-1:0]            w_pass_inc;
    logic                         w_enter_final;
    logic signed [DATA_WIDTH-1:0] w_rd;
    logic signed [DATA_WIDTH-1:0] w_sat;
    logic signed [DATA_WIDTH-1:0] w_final_sum;
    logic signed [DATA_WIDTH-1:0] w_push_data;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_drop;
    logic                         w_done;
    logic                         w_fifo_full;
    logic                         w_fifo_empty;
    logic [DATA_WIDTH-1:0]        w_fifo_dout;

    assign w_accept      = bus.i_psum_valid & ((r_state == ACCUM) | (r_state == FINAL));
    assign w_last_col    = ({1'b0, r_col_ptr} == (r_width - 1'b1));
    assign w_pass_inc    = {1'b0, r_pass_ptr} + 1'b1;
    // The pass about to start is the last one once the incremented pointer hits num_pass-1.
    assign w_enter_final = (w_pass_inc == (r_num_pass - 1'b1));
    assign w_rd          = r_buf[r_col_ptr];
    assign w_sat         = DATA_WIDTH'(sat_add(32'(w_rd), 32'(bus.i_psum_data), DATA_WIDTH));
    // A single-pass job never wrote the buffer, so the psum is the final sum.
    assign w_final_sum   = (r_num_pass == c_NP_W'(1)) ? bus.i_psum_data : w_sat;
    assign w_push_data   = r_relu_en ? DATA_WIDTH'(relu(32'(w_final_sum))) : w_final_sum;
    assign w_push        = w_accept & (r_state == FINAL);
    assign w_pop         = ~w_fifo_empty & bus.i_ofmap_ready;
    assign w_drop        = w_push & w_fifo_full & ~w_pop;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state and done-pulse decode.
    always_comb begin
        w_next_state = r_state;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_next_state = (bus.i_num_pass == c_NP_W'(1)) ? FINAL : ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept && w_last_col && w_enter_final) w_next_state = FINAL;
            end
            FINAL: begin
                if (w_accept && w_last_col) w_next_state = DRAIN;
            end
            DRAIN: begin
                if (w_fifo_empty) begin
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Config latch, column/pass pointers and sticky drop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col_ptr  <= '0;
            r_pass_ptr <= '0;
            r_width    <= '0;
            r_num_pass <= '0;
            r_relu_en  <= 1'b0;
            r_drop_err <= 1'b0;
        end else if ((r_state == IDLE) && bus.i_start) begin
            r_col_ptr  <= '0;
            r_pass_ptr <= '0;
            r_width    <= bus.i_ofmap_width;
            r_num_pass <= bus.i_num_pass;
            r_relu_en  <= bus.i_relu_en;
            r_drop_err <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_last_col) begin
                    r_col_ptr  <= '0;
                    r_pass_ptr <= r_pass_ptr + 1'b1;
                end else begin
                    r_col_ptr  <= r_col_ptr + 1'b1;
                end
            end
            if (w_drop) r_drop_err <= 1'b1;
        end
    end

    // Accumulator buffer: pass 0 overwrites, later non-final passes saturate-add.
    always_ff @(posedge clk) begin
        if (w_accept && (r_state == ACCUM)) begin
            r_buf[r_col_ptr] <= (r_pass_ptr == '0) ? bus.i_psum_data : w_sat;
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (w_push_data),
        .full  (w_fifo_full),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .empty (w_fifo_empty)
    );

    assign bus.o_ofmap_data  = w_fifo_dout;
    assign bus.o_ofmap_valid = ~w_fifo_empty;
    assign bus.o_busy        = (r_state != IDLE);
    assign bus.o_done        = w_done;
    assign bus.o_drop_err    = r_drop_err;
endmodule
`default_nettype wire

// File: tb/tb_psum_accum_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_psum_accum_buffer                                        |
// | Self-checking bench: directed jobs plus randomized jobs compared     |
// | against a column-sum reference model.                               |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_psum_accum_buffer;
    localparam int DW = 16;
    localparam int MW = 64;
    localparam int MP = 256;
    localparam int FD = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    psum_accum_buffer_if #(.DATA_WIDTH(DW), .MAX_OFMAP_WIDTH(MW), .MAX_PASSES(MP)) bus ();

    psum_accum_buffer #(
        .DATA_WIDTH      (DW),
        .MAX_OFMAP_WIDTH (MW),
        .MAX_PASSES      (MP),
        .FIFO_DEPTH      (FD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int done_cnt     = 0;
    int done_cyc     = -1;
    int last_pop_cyc = -1;
    int got[$];
    int expq[$];
    int ps [MP][MW];

    // Cycle counter.
    always @(posedge clk) cyc++;

    // Output monitor: records every word handed over and every done pulse.
    always @(negedge clk) begin
        if (bus.o_ofmap_valid === 1'b1 && bus.i_ofmap_ready === 1'b1) begin
            got.push_back(int'(bus.o_ofmap_data));
            last_pop_cyc = cyc;
        end
        if (bus.o_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat16(input int x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int rnd_val(input bit big);
        logic signed [15:0] t;
        t = 16'($urandom);
        if (big) return int'(t);
        return int'($urandom_range(0, 400)) - 200;
    endfunction

    // Reference: per column, sum the passes in order with saturation at every step.
    task automatic build_exp(input int w, input int p, input bit relu);
        int acc;
        expq.delete();
        for (int c = 0; c < w; c++) begin
            acc = ps[0][c];
            for (int k = 1; k < p; k++) acc = sat16(acc + ps[k][c]);
            if (relu && acc < 0) acc = 0;
            expq.push_back(acc);
        end
    endtask

    task automatic start_job(input int w, input int p, input bit relu);
        bus.i_ofmap_width = 7'(w);
        bus.i_num_pass    = 9'(p);
        bus.i_relu_en     = relu;
        bus.i_start       = 1'b1;
        tick();
        bus.i_start       = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 400 && done_cnt == d0; i++) tick();
        chk("done_seen", longint'(done_cnt != d0), 1);
    endtask

    // Runs one job with ready held high; 'noisy' inserts idle gaps carrying ignored i_start pulses.
    task automatic run_job(input int w, input int p, input bit relu, input bit noisy);
        int d0;
        build_exp(w, p, relu);
        got.delete();
        d0 = done_cnt;
        bus.i_ofmap_ready = 1'b1;
        start_job(w, p, relu);
        chk("busy_after_start", bus.o_busy, 1);
        chk("drop_clear_on_start", bus.o_drop_err, 0);
        for (int k = 0; k < p; k++) begin
            for (int c = 0; c < w; c++) begin
                bus.i_psum_data  = 16'(ps[k][c]);
                bus.i_psum_valid = 1'b1;
                tick();
                if (k == p - 1 && c == 0) begin
                    chk("latency_valid", bus.o_ofmap_valid, 1);
                    chk("latency_data", int'(bus.o_ofmap_data), expq[0]);
                end
                bus.i_psum_valid = 1'b0;
                if (noisy && $urandom_range(0, 3) == 0) begin
                    bus.i_start       = 1'($urandom_range(0, 1));
                    bus.i_ofmap_width = 7'd1;
                    bus.i_num_pass    = 9'd1;
                    bus.i_relu_en     = ~relu;
                    tick();
                    bus.i_start       = 1'b0;
                end
            end
        end
        wait_done(d0);
        chk("out_count", got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk($sformatf("out[%0d] w=%0d p=%0d", i, w, p), got[i], expq[i]);
        chk("done_after_last_pop", done_cyc - last_pop_cyc, 1);
        chk("idle_after_done", bus.o_busy, 0);
        tick();
        chk("done_single_pulse", done_cnt - d0, 1);
    endtask

    task automatic fill_rand(input int w, input int p, input bit big);
        for (int k = 0; k < p; k++)
            for (int c = 0; c < w; c++) ps[k][c] = rnd_val(big && ($urandom_range(0, 1) == 1));
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        bus.i_start = 1'b0; bus.i_ofmap_width = '0; bus.i_num_pass = '0; bus.i_relu_en = 1'b0;
        bus.i_psum_data = '0; bus.i_psum_valid = 1'b0; bus.i_ofmap_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_valid", bus.o_ofmap_valid, 0);
        chk("rst_data", bus.o_ofmap_data, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_drop", bus.o_drop_err, 0);
        reset = 1'b0;
        tick();

        // Single pass, values passed straight through in order.
        ps[0][0] = 1; ps[0][1] = -2; ps[0][2] = 3; ps[0][3] = 4;
        run_job(4, 1, 1'b0, 1'b0);

        // Three passes accumulate to 111/222/333.
        ps[0][0] = 1;   ps[0][1] = 2;   ps[0][2] = 3;
        ps[1][0] = 10;  ps[1][1] = 20;  ps[1][2] = 30;
        ps[2][0] = 100; ps[2][1] = 200; ps[2][2] = 300;
        run_job(3, 3, 1'b0, 1'b0);

        // Saturation both ways, then ReLU on the negative clamp.
        ps[0][0] = 32000; ps[0][1] = -32000;
        ps[1][0] = 1000;  ps[1][1] = -1000;
        run_job(2, 2, 1'b0, 1'b0);
        chk("sat_pos", got[0], 32767);
        chk("sat_neg", got[1], -32768);
        run_job(2, 2, 1'b1, 1'b0);
        chk("sat_neg_relu", got[1], 0);

        // FIFO overflow with consumer stalled: 8 kept, 9th and 10th dropped.
        for (int c = 0; c < 10; c++) ps[0][c] = 100 + c;
        got.delete();
        d0 = done_cnt;
        bus.i_ofmap_ready = 1'b0;
        start_job(10, 1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            bus.i_psum_data  = 16'(ps[0][c]);
            bus.i_psum_valid = 1'b1;
            tick();
            if (c == 7) chk("no_drop_at_8", bus.o_drop_err, 0);
            if (c == 8) chk("drop_after_9", bus.o_drop_err, 1);
        end
        bus.i_psum_valid = 1'b0;
        chk("head_hold", bus.o_ofmap_data, 100);
        tick();
        chk("head_hold2", bus.o_ofmap_data, 100);
        bus.i_ofmap_ready = 1'b1;
        wait_done(d0);
        chk("drop_out_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk($sformatf("drop_out[%0d]", i), got[i], 100 + i);
        chk("drop_sticky", bus.o_drop_err, 1);

        // Push into a full FIFO in the same cycle as a pop: no loss.
        for (int c = 0; c < 9; c++) ps[0][c] = -50 - c;
        got.delete();
        d0 = done_cnt;
        bus.i_ofmap_ready = 1'b0;
        start_job(9, 1, 1'b0);
        for (int c = 0; c < 9; c++) begin
            if (c == 8) bus.i_ofmap_ready = 1'b1;
            bus.i_psum_data  = 16'(ps[0][c]);
            bus.i_psum_valid = 1'b1;
            tick();
        end
        bus.i_psum_valid = 1'b0;
        chk("full_pop_no_drop", bus.o_drop_err, 0);
        wait_done(d0);
        chk("full_pop_count", got.size(), 9);
        for (int i = 0; i < 9 && i < got.size(); i++) chk($sformatf("full_pop_out[%0d]", i), got[i], -50 - i);

        // Reset in the middle of pass 1 of a 3-pass job.
        d0 = done_cnt;
        start_job(4, 3, 1'b0);
        for (int n = 0; n < 6; n++) begin
            bus.i_psum_data  = 16'(7 * n + 5);
            bus.i_psum_valid = 1'b1;
            tick();
        end
        bus.i_psum_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("midrst_busy", bus.o_busy, 0);
        chk("midrst_valid", bus.o_ofmap_valid, 0);
        chk("midrst_data", bus.o_ofmap_data, 0);
        chk("midrst_drop", bus.o_drop_err, 0);
        reset = 1'b0;
        tick();
        chk("midrst_no_done", done_cnt - d0, 0);
        fill_rand(4, 3, 1'b0);
        run_job(4, 3, 1'b0, 1'b0);

        // Psum pulses while idle are ignored.
        for (int n = 0; n < 3; n++) begin
            bus.i_psum_data  = 16'(777);
            bus.i_psum_valid = 1'b1;
            tick();
        end
        bus.i_psum_valid = 1'b0;
        chk("idle_psum_busy", bus.o_busy, 0);
        chk("idle_psum_valid", bus.o_ofmap_valid, 0);
        fill_rand(3, 2, 1'b1);
        run_job(3, 2, 1'b0, 1'b0);

        // Randomized jobs, with ignored i_start pulses during the job.
        for (int j = 0; j < 10; j++) begin
            int w;
            int p;
            bit r;
            w = int'($urandom_range(1, 12));
            p = int'($urandom_range(1, 5));
            r = 1'($urandom_range(0, 1));
            fill_rand(w, p, 1'b1);
            run_job(w, p, r, 1'b1);
        end

        // Boundary sizes: widest row, deepest accumulation.
        fill_rand(64, 1, 1'b1);
        run_job(64, 1, 1'b1, 1'b0);
        fill_rand(2, 256, 1'b0);
        run_job(2, 256, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
